// File: rtl/bk_save_ctrl_pkg.sv
// Shared types and constants for the backup-RAM save controller.
// Format header words and the slot-to-LBA mapping live here.
package bk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FORMAT,
    XFER_REQ,
    XFER_WAIT
  } bk_state_t;

  localparam int FMT_MAX = 8;

  // Entry 0 is the rightmost word.
  localparam logic [FMT_MAX-1:0][15:0] FMT_PATTERN = {
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h8010, 16'h8800, 16'h4D42, 16'h5548
  };

  function automatic logic [31:0] lba_base(
    input logic [31:0] slot,
    input int unsigned sectors
  );
    return slot * 32'(sectors);
  endfunction

endpackage

// File: rtl/bk_save_ctrl_if.sv
// HPS sd_* block-transfer bundle between hps_io and the save controller.
// master = controller side, slave = HPS side.
interface bk_save_ctrl_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;

  modport master (
    output sd_lba, sd_rd, sd_wr,
    input  sd_ack, sd_buff_addr,
    input  sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr,
    output sd_ack, sd_buff_addr,
    output sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/bk_save_ctrl_sector_seq.sv
// Sector sequencer: sd_rd/sd_wr request vs sd_ack handshake,
// plus the sector index and LBA counters of one slot transfer.
module bk_sector_seq #(
  parameter int SECTORS = 16,
  parameter int IW      = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic          i_load,
  input  logic [31:0]   i_base,
  input  logic          i_ena,
  input  logic          i_ack,
  output logic [IW-1:0] o_idx,
  output logic [31:0]   o_lba,
  output logic          o_rd,
  output logic          o_wr,
  output logic          o_ack_rise,
  output logic          o_next,
  output logic          o_done
);

  logic          r_go;
  logic          r_req;
  logic          r_wait;
  logic          r_load;
  logic          r_ack_q;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_lba;

  logic w_rise, w_fall, w_last, w_done, w_next;

  assign w_rise = i_ack & ~r_ack_q & r_req;
  assign w_fall = ~i_ack & r_ack_q & r_wait;
  assign w_last = (r_idx == IW'(SECTORS - 1));
  assign w_done = w_fall & (w_last | ~i_ena);
  assign w_next = w_fall & ~w_done;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_go    <= 1'b0;
      r_req   <= 1'b0;
      r_wait  <= 1'b0;
      r_load  <= 1'b0;
      r_ack_q <= 1'b0;
      r_idx   <= '0;
      r_lba   <= '0;
    end else begin
      r_ack_q <= i_ack;
      if (i_start) begin
        r_go   <= 1'b1;
        r_req  <= 1'b0;
        r_wait <= 1'b0;
        r_load <= i_load;
        r_idx  <= '0;
        r_lba  <= i_base;
      end else if (r_go) begin
        r_go  <= 1'b0;
        r_req <= 1'b1;
      end else if (w_rise) begin
        r_req  <= 1'b0;
        r_wait <= 1'b1;
      end else if (w_next) begin
        r_wait <= 1'b0;
        r_req  <= 1'b1;
        r_idx  <= r_idx + 1'b1;
        r_lba  <= r_lba + 32'd1;
      end else if (w_done) begin
        r_wait <= 1'b0;
      end
    end
  end

  // Request drops in the same cycle the HPS raises ack.
  assign o_rd       = r_req & r_load & ~i_ack;
  assign o_wr       = r_req & ~r_load & ~i_ack;
  assign o_idx      = r_idx;
  assign o_lba      = r_lba;
  assign o_ack_rise = w_rise;
  assign o_next     = w_next;
  assign o_done     = w_done;

endmodule

// File: rtl/bk_save_ctrl.sv
// Backup-RAM save/load/format controller with N slots and dirty tracking.
// Optional BK_AUTOSAVE_EN: OSD-open triggers a save of pending data.
module bk_save_ctrl
  import bk_pkg::*;
#(
  parameter int SECTORS   = 16,
  parameter int SLOTS     = 1,
  parameter int FMT_WORDS = 4
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      ena,
  input  logic                      img_nz,
  input  logic                      dl_end,
  input  logic                      load_req,
  input  logic                      save_req,
  input  logic                      fmt_req,
  input  logic [$clog2(SLOTS):0]    slot,
  input  logic                      osd_status,
  input  logic                      autosave,
  input  logic                      cpu_wr,
  bk_save_ctrl_if.master            sd,
  output logic [$clog2(SECTORS)+7:0] ram_addr_b,
  output logic [15:0]               ram_din_b,
  output logic                      ram_we_b,
  output logic                      busy,
  output logic                      loading,
  output logic                      pending
);

  localparam int SW = $clog2(SLOTS) + 1;
  localparam int AW = $clog2(SECTORS) + 8;
  localparam int IW = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam int FW = (FMT_WORDS > 1) ? $clog2(FMT_WORDS) : 1;

  bk_state_t     r_state;
  logic [FW-1:0] r_fmt_cnt;
  logic [SW-1:0] r_slot;
  logic          r_load_q, r_save_q, r_fmt_q;

  logic          w_idle_ok, w_fmt_rise, w_load_rise, w_save_rise;
  logic          w_auto, w_fmt, w_load, w_save;
  logic [SW-1:0] w_slot_in, w_acc_slot;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_lba;
  logic          w_ack_rise, w_next, w_done, w_xfer;
  logic [IW+7:0] w_xaddr;

  assign w_idle_ok   = (r_state == IDLE) & ena;
  assign w_fmt_rise  = fmt_req & ~r_fmt_q;
  assign w_load_rise = load_req & ~r_load_q;
  assign w_save_rise = save_req & ~r_save_q;

`ifdef BK_AUTOSAVE_EN
  logic r_osd_q;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_osd_q <= 1'b0;
    else          r_osd_q <= osd_status;
  end
  assign w_auto = osd_status & ~r_osd_q & autosave & pending;
`else
  logic w_unused_autosave;
  assign w_unused_autosave = autosave;
  assign w_auto = 1'b0;
`endif

  assign w_fmt  = w_idle_ok & w_fmt_rise;
  assign w_load = w_idle_ok & ~w_fmt_rise &
                  (w_load_rise | (dl_end & img_nz));
  assign w_save = w_idle_ok & ~w_fmt_rise & ~w_load &
                  (w_save_rise | w_auto);

  // Autosave has no slot of its own and reuses the last one.
  assign w_slot_in  = (32'(slot) >= 32'(SLOTS)) ? '0 : slot;
  assign w_acc_slot = (w_save & ~w_save_rise) ? r_slot : w_slot_in;

  bk_sector_seq #(
    .SECTORS (SECTORS),
    .IW      (IW)
  ) u_seq (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .i_start    (w_load | w_save),
    .i_load     (w_load),
    .i_base     (lba_base(32'(w_acc_slot), SECTORS)),
    .i_ena      (ena),
    .i_ack      (sd.sd_ack),
    .o_idx      (w_idx),
    .o_lba      (w_lba),
    .o_rd       (sd.sd_rd),
    .o_wr       (sd.sd_wr),
    .o_ack_rise (w_ack_rise),
    .o_next     (w_next),
    .o_done     (w_done)
  );

  assign sd.sd_lba = w_lba;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_fmt_cnt <= '0;
      r_slot    <= '0;
      r_load_q  <= 1'b0;
      r_save_q  <= 1'b0;
      r_fmt_q   <= 1'b0;
      busy      <= 1'b0;
      loading   <= 1'b0;
      pending   <= 1'b0;
    end else begin
      r_load_q <= load_req;
      r_save_q <= save_req;
      r_fmt_q  <= fmt_req;
      if (cpu_wr & ena & ~osd_status & ~loading)
        pending <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_fmt) begin
            r_state   <= FORMAT;
            r_fmt_cnt <= '0;
            busy      <= 1'b1;
            pending   <= 1'b1;
          end else if (w_load | w_save) begin
            r_state <= XFER_REQ;
            r_slot  <= w_acc_slot;
            busy    <= 1'b1;
            loading <= w_load;
            if (w_save) pending <= 1'b0;
          end
        end
        FORMAT: begin
          if (r_fmt_cnt == FW'(FMT_WORDS - 1)) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_fmt_cnt <= r_fmt_cnt + 1'b1;
          end
        end
        XFER_REQ: begin
          if (w_ack_rise) r_state <= XFER_WAIT;
        end
        XFER_WAIT: begin
          if (w_done) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            loading <= 1'b0;
            if (loading) pending <= 1'b0;
          end else if (w_next) begin
            r_state <= XFER_REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_xfer  = (r_state == XFER_REQ) | (r_state == XFER_WAIT);
  assign w_xaddr = {w_idx, sd.sd_buff_addr};

  always_comb begin
    ram_addr_b = '0;
    ram_din_b  = '0;
    if (w_xfer) begin
      ram_addr_b = AW'(w_xaddr);
      ram_din_b  = sd.sd_buff_dout;
    end else if (r_state == FORMAT) begin
      ram_addr_b = AW'(r_fmt_cnt);
      ram_din_b  = FMT_PATTERN[r_fmt_cnt];
    end
  end

  assign ram_we_b = (sd.sd_buff_wr & sd.sd_ack & loading) |
                    (r_state == FORMAT);

endmodule

// File: tb/tb_bk_save_ctrl.sv
// Directed bench for bk_save_ctrl with an HPS sector model and a
// scoreboard of expected port-B writes.
module tb_bk_save_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ena = 1'b0, img_nz = 1'b0, dl_end = 1'b0;
  logic        load_req = 1'b0, save_req = 1'b0, fmt_req = 1'b0;
  logic [2:0]  slot = 3'd0;
  logic        osd_status = 1'b0, autosave = 1'b0, cpu_wr = 1'b0;
  logic [11:0] ram_addr_b;
  logic [15:0] ram_din_b;
  logic        ram_we_b, busy, loading, pending;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [27:0] exp_q[$];
  logic [15:0] fmt_exp[4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

  always #5 clk_sys = ~clk_sys;

  bk_save_ctrl_if sd();

  bk_save_ctrl #(
    .SECTORS   (16),
    .SLOTS     (4),
    .FMT_WORDS (4)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ena        (ena),
    .img_nz     (img_nz),
    .dl_end     (dl_end),
    .load_req   (load_req),
    .save_req   (save_req),
    .fmt_req    (fmt_req),
    .slot       (slot),
    .osd_status (osd_status),
    .autosave   (autosave),
    .cpu_wr     (cpu_wr),
    .sd         (sd),
    .ram_addr_b (ram_addr_b),
    .ram_din_b  (ram_din_b),
    .ram_we_b   (ram_we_b),
    .busy       (busy),
    .loading    (loading),
    .pending    (pending)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (ram_we_b === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("ram_we_unexpected", 64'(ram_we_b), 64'd0);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        check("ram_write", {36'd0, ram_addr_b, ram_din_b}, {36'd0, e});
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    @(negedge clk_sys);
    while (sd.sd_rd !== 1'b1 && sd.sd_wr !== 1'b1 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("req_seen", 64'(sd.sd_rd | sd.sd_wr), 64'd1);
  endtask

  task automatic no_req(input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk_sys);
      seen = seen | sd.sd_rd | sd.sd_wr;
    end
    check("no_req", 64'(seen), 64'd0);
  endtask

  task automatic run_sector(input logic [31:0] lba, input bit is_load,
                            input int words, input int idx,
                            input bit drop_ena);
    wait_req();
    check("sd_lba", sd.sd_lba, lba);
    check("sd_dir", {62'd0, sd.sd_rd, sd.sd_wr},
          is_load ? 64'd2 : 64'd1);
    @(posedge clk_sys); #1;
    sd.sd_ack = 1'b1;
    if (drop_ena) ena = 1'b0;
    for (int w = 0; w < words; w++) begin
      @(posedge clk_sys); #1;
      sd.sd_buff_addr = 8'(w);
      sd.sd_buff_dout = 16'($urandom);
      sd.sd_buff_wr   = 1'b1;
      if (is_load)
        exp_q.push_back({12'(idx * 256 + w), sd.sd_buff_dout});
    end
    @(posedge clk_sys); #1;
    sd.sd_buff_wr = 1'b0;
    @(posedge clk_sys); #1;
    sd.sd_ack = 1'b0;
  endtask

  task automatic pulse_cpu_wr();
    @(posedge clk_sys); #1;
    cpu_wr = 1'b1;
    @(posedge clk_sys); #1;
    cpu_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    sd.sd_ack       = 1'b0;
    sd.sd_buff_addr = 8'd0;
    sd.sd_buff_dout = 16'd0;
    sd.sd_buff_wr   = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_outs", {55'd0, busy, loading, pending, sd.sd_rd,
          sd.sd_wr, ram_we_b}, 64'd0);
    check("rst_lba", sd.sd_lba, 64'd0);
    check("rst_addr", {36'd0, ram_addr_b, ram_din_b}, 64'd0);
    reset_n = 1'b1;
    ena = 1'b1;
    img_nz = 1'b1;

    // full 16-sector load of slot 0
    pulse_cpu_wr();
    check("pending_set", 64'(pending), 64'd1);
    @(posedge clk_sys); #1;
    load_req = 1'b1;
    for (int s = 0; s < 16; s++) begin
      run_sector(32'(s), 1'b1, 256, s, 1'b0);
      if (s == 0)
        check("load_busy", {62'd0, busy, loading}, 64'd3);
    end
    repeat (2) @(negedge clk_sys);
    check("load_done", {62'd0, busy, loading}, 64'd0);
    check("load_pending_clr", 64'(pending), 64'd0);
    check("load_q_empty", 64'(exp_q.size()), 64'd0);
    load_req = 1'b0;

    // format and load in the same cycle: format wins
    @(posedge clk_sys); #1;
    fmt_req  = 1'b1;
    load_req = 1'b1;
    for (int i = 0; i < 4; i++)
      exp_q.push_back({12'(i), fmt_exp[i]});
    no_req(30);
    check("fmt_q_empty", 64'(exp_q.size()), 64'd0);
    check("fmt_idle", 64'(busy), 64'd0);
    check("fmt_pending", 64'(pending), 64'd1);
    fmt_req  = 1'b0;
    load_req = 1'b0;

    // save of slot 2, cpu write mid-save re-marks dirty
    slot = 3'd2;
    @(posedge clk_sys); #1;
    save_req = 1'b1;
    for (int s = 0; s < 16; s++) begin
      run_sector(32'(32 + s), 1'b0, 4, s, 1'b0);
      if (s == 0)
        check("save_pending_clr", 64'(pending), 64'd0);
      if (s == 3) begin
        pulse_cpu_wr();
        check("save_pending_reset", 64'(pending), 64'd1);
      end
    end
    repeat (2) @(negedge clk_sys);
    check("save_done", {62'd0, busy, loading}, 64'd0);
    save_req = 1'b0;

    // ena drop during sector 5 of a load
    slot = 3'd0;
    @(posedge clk_sys); #1;
    load_req = 1'b1;
    for (int s = 0; s < 5; s++)
      run_sector(32'(s), 1'b1, 8, s, 1'b0);
    run_sector(32'd5, 1'b1, 8, 5, 1'b1);
    no_req(30);
    check("abort_idle", {62'd0, busy, loading}, 64'd0);
    check("abort_lba", sd.sd_lba, 64'd5);
    check("abort_q_empty", 64'(exp_q.size()), 64'd0);
    load_req = 1'b0;
    ena = 1'b1;

    // async reset with sd_rd high, then out-of-range slot clamps to 0
    slot = 3'd1;
    @(posedge clk_sys); #1;
    load_req = 1'b1;
    wait_req();
    check("slot1_lba", sd.sd_lba, 64'd16);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_outs", {56'd0, busy, loading, pending, sd.sd_rd,
          sd.sd_wr, ram_we_b}, 64'd0);
    check("arst_lba", sd.sd_lba, 64'd0);
    load_req = 1'b0;
    slot = 3'd6;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    load_req = 1'b1;
    wait_req();
    check("clamp_lba", sd.sd_lba, 64'd0);
    load_req = 1'b0;
    do_reset();

    // download end starts a load of slot 3
    slot = 3'd3;
    @(posedge clk_sys); #1;
    dl_end = 1'b1;
    @(posedge clk_sys); #1;
    dl_end = 1'b0;
    wait_req();
    check("dl_lba", sd.sd_lba, 64'd48);
    check("dl_rd", 64'(sd.sd_rd), 64'd1);
    do_reset();

    // autosave on OSD open
    slot = 3'd0;
    pulse_cpu_wr();
    check("auto_pending", 64'(pending), 64'd1);
    autosave = 1'b1;
    @(posedge clk_sys); #1;
    osd_status = 1'b1;
`ifdef BK_AUTOSAVE_EN
    wait_req();
    check("auto_wr", {62'd0, sd.sd_rd, sd.sd_wr}, 64'd1);
    check("auto_lba", sd.sd_lba, 64'd0);
`else
    no_req(30);
    check("auto_off_pending", 64'(pending), 64'd1);
`endif
    do_reset();
    repeat (2) @(negedge clk_sys);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
